// File: rtl/hack_pc_stack.sv
// rtl/hack_pc_stack.sv - HACK program counter with hardware return-address stack
module hack_pc_stack #(
  parameter int                 WIDTH        = 16,
  parameter int                 STACK_DEPTH  = 8,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
  localparam int                DW           = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             increment,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [DW-1:0]    depth,
  output logic             overflow,
  output logic             underflow
);

  // Index width for the stack array; a single-entry stack still needs one bit.
  localparam int              IW      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DW-1:0]   LP_FULL = DW'(STACK_DEPTH);

  logic [WIDTH-1:0] r_pc;
  logic [DW-1:0]    r_depth;
  logic             r_overflow;
  logic             r_underflow;
  logic [WIDTH-1:0] r_stack [STACK_DEPTH];

  logic             w_do_load;
  logic             w_do_call;
  logic             w_do_ret;
  logic             w_do_inc;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_pc_plus1;
  logic [IW-1:0]    w_push_idx;
  logic [IW-1:0]    w_pop_idx;
  logic [DW-1:0]    w_depth_m1;
  logic [WIDTH-1:0] w_pc_next;
  logic [DW-1:0]    w_depth_next;
  logic             w_overflow_next;
  logic             w_underflow_next;

  assign w_full     = (r_depth == LP_FULL);
  assign w_empty    = (r_depth == '0);
  assign w_pc_plus1 = r_pc + 1'b1;
  assign w_depth_m1 = r_depth - 1'b1;
  assign w_push_idx = r_depth[IW-1:0];
  assign w_pop_idx  = w_depth_m1[IW-1:0];

  // Resolve simultaneous controls to one winning command: load > call > ret > increment.
  always_comb begin
    w_do_load = 1'b0;
    w_do_call = 1'b0;
    w_do_ret  = 1'b0;
    w_do_inc  = 1'b0;
    if (load) begin
      w_do_load = 1'b1;
    end else if (call) begin
      w_do_call = 1'b1;
    end else if (ret) begin
      w_do_ret = 1'b1;
    end else if (increment) begin
      w_do_inc = 1'b1;
    end
  end

  // A push only happens on a call with room; a pop only on a ret with an entry, never both.
  assign w_push = w_do_call && !w_full;
  assign w_pop  = w_do_ret && !w_empty;

  // Next-state values for the counter, depth and sticky error flags.
  always_comb begin
    w_pc_next        = r_pc;
    w_depth_next     = r_depth;
    w_overflow_next  = r_overflow;
    w_underflow_next = r_underflow;
    if (w_do_load) begin
      w_pc_next = in;
    end else if (w_do_call) begin
      w_pc_next = in;
      if (w_push) begin
        w_depth_next = r_depth + 1'b1;
      end else begin
        w_overflow_next = 1'b1;
      end
    end else if (w_do_ret) begin
      if (w_pop) begin
        w_pc_next    = r_stack[w_pop_idx];
        w_depth_next = w_depth_m1;
      end else begin
        w_underflow_next = 1'b1;
      end
    end else if (w_do_inc) begin
      w_pc_next = w_pc_plus1;
    end
  end

  // Counter, depth and flag registers; reset also discards every stack entry by zeroing depth.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc        <= RESET_VECTOR;
      r_depth     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pc        <= w_pc_next;
      r_depth     <= w_depth_next;
      r_overflow  <= w_overflow_next;
      r_underflow <= w_underflow_next;
    end
  end

  // Return-address storage; contents are meaningless above depth, so no reset is needed.
  always_ff @(posedge clock) begin
    if (!reset && w_push) begin
      r_stack[w_push_idx] <= w_pc_plus1;
    end
  end

  assign out       = r_pc;
  assign depth     = r_depth;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_hack_pc_stack.sv
// tb/tb_hack_pc_stack.sv - directed self-checking bench for hack_pc_stack
module tb_hack_pc_stack;

  localparam int WIDTH = 16;
  localparam int SD    = 8;
  localparam int DW    = $clog2(SD + 1);
  localparam logic [WIDTH-1:0] RV = 16'h0010;

  logic             clock;
  logic             reset;
  logic             load;
  logic             increment;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic [DW-1:0]    depth;
  logic             overflow;
  logic             underflow;

  int n_checks = 0;
  int n_fails  = 0;

  hack_pc_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (SD),
    .RESET_VECTOR(RV)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .increment(increment),
    .call     (call),
    .ret      (ret),
    .in       (in),
    .out      (out),
    .depth    (depth),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of controls, then sample 1 time unit after the edge.
  task automatic cmd(input logic rs, input logic ld, input logic inc, input logic cl,
                     input logic rt, input logic [WIDTH-1:0] din);
    reset     = rs;
    load      = ld;
    increment = inc;
    call      = cl;
    ret       = rt;
    in        = din;
    @(posedge clock);
    #1;
    reset     = 1'b0;
    load      = 1'b0;
    increment = 1'b0;
    call      = 1'b0;
    ret       = 1'b0;
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; increment = 1'b0; call = 1'b0; ret = 1'b0; in = '0;
    @(negedge clock);

    // Reset state and hold
    cmd(1, 0, 0, 0, 0, 16'h0);
    check("rst_out", 32'(out), 32'h0010);
    check("rst_depth", 32'(depth), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_unf", 32'(underflow), 0);
    for (int i = 0; i < 3; i++) begin
      cmd(0, 0, 0, 0, 0, 16'hABCD);
      check("hold_out", 32'(out), 32'h0010);
    end
    check("hold_depth", 32'(depth), 0);

    // Increment wrap, load beats increment
    cmd(0, 1, 0, 0, 0, 16'hFFFE);
    check("load_fffe", 32'(out), 32'hFFFE);
    cmd(0, 0, 1, 0, 0, 16'h0);
    check("inc_ffff", 32'(out), 32'hFFFF);
    cmd(0, 0, 1, 0, 0, 16'h0);
    check("inc_wrap", 32'(out), 32'h0000);
    cmd(0, 1, 1, 0, 0, 16'h1234);
    check("load_inc", 32'(out), 32'h1234);

    // Single call / return
    cmd(0, 1, 0, 0, 0, 16'h0005);
    cmd(0, 0, 0, 1, 0, 16'h0100);
    check("call_out", 32'(out), 32'h0100);
    check("call_depth", 32'(depth), 1);
    cmd(0, 0, 1, 0, 0, 16'h0);
    cmd(0, 0, 1, 0, 0, 16'h0);
    check("sub_inc", 32'(out), 32'h0102);
    cmd(0, 0, 0, 0, 1, 16'h0);
    check("ret_out", 32'(out), 32'h0006);
    check("ret_depth", 32'(depth), 0);

    // Nested calls to full, overflow, then unwind
    cmd(0, 1, 0, 0, 0, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      cmd(0, 0, 0, 1, 0, 16'((k + 1) * 16));
      check("nest_out", 32'(out), 32'((k + 1) * 16));
      check("nest_depth", 32'(depth), 32'(k + 1));
    end
    check("full_ovf", 32'(overflow), 0);
    cmd(0, 0, 0, 1, 0, 16'h0900);
    check("ovf_out", 32'(out), 32'h0900);
    check("ovf_depth", 32'(depth), 8);
    check("ovf_flag", 32'(overflow), 1);
    for (int k = 7; k >= 0; k--) begin
      cmd(0, 0, 0, 0, 1, 16'h0);
      check("unwind_out", 32'(out), 32'(k * 16 + 1));
      check("unwind_depth", 32'(depth), 32'(k));
    end
    check("ovf_sticky", 32'(overflow), 1);
    check("no_unf", 32'(underflow), 0);

    // Underflow and its stickiness
    cmd(0, 1, 0, 0, 0, 16'h0042);
    cmd(0, 0, 0, 0, 1, 16'h0);
    check("unf_out", 32'(out), 32'h0042);
    check("unf_depth", 32'(depth), 0);
    check("unf_flag", 32'(underflow), 1);
    cmd(0, 0, 0, 1, 0, 16'h0050);
    check("unf_call", 32'(out), 32'h0050);
    check("unf_sticky1", 32'(underflow), 1);
    cmd(0, 0, 0, 0, 1, 16'h0);
    check("unf_ret", 32'(out), 32'h0043);
    check("unf_sticky2", 32'(underflow), 1);

    // Priority: call+ret is a call, load+call is a plain jump
    cmd(0, 1, 0, 0, 0, 16'h0007);
    cmd(0, 0, 0, 1, 1, 16'h0200);
    check("cr_out", 32'(out), 32'h0200);
    check("cr_depth", 32'(depth), 1);
    cmd(0, 1, 0, 1, 0, 16'h0300);
    check("lc_out", 32'(out), 32'h0300);
    check("lc_depth", 32'(depth), 1);
    cmd(0, 0, 0, 0, 1, 16'h0);
    check("cr_top", 32'(out), 32'h0008);
    check("cr_depth0", 32'(depth), 0);

    // Reset beats call at depth 3 and discards the stack
    cmd(0, 0, 0, 1, 0, 16'h0400);
    cmd(0, 0, 0, 1, 0, 16'h0500);
    cmd(0, 0, 0, 1, 0, 16'h0600);
    check("pre_rst_depth", 32'(depth), 3);
    cmd(1, 0, 0, 1, 0, 16'h0700);
    check("rc_out", 32'(out), 32'h0010);
    check("rc_depth", 32'(depth), 0);
    check("rc_ovf", 32'(overflow), 0);
    check("rc_unf", 32'(underflow), 0);
    cmd(0, 0, 0, 0, 1, 16'h0);
    check("rc_ret_out", 32'(out), 32'h0010);
    check("rc_ret_unf", 32'(underflow), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/hack_pc_stack.md
Name: hack_pc_stack

Overview:
- Parametrised program counter for the HACK CPU.
- Adds a hardware return-address stack for call/return on top of the classic reset/load/increment counter.
- Width, stack depth and reset vector are generic.
- Sits in the CPU fetch path; `out` drives instruction-memory address; `in` comes from the A register / jump target.

Parameters:
- WIDTH, 16, bit width of PC, `in`, `out` and stack entries (>=2).
- STACK_DEPTH, 8, number of return-address entries (>=1).
- RESET_VECTOR, 0, value loaded into PC on reset (WIDTH bits).

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  PC <= in (jump).
- increment  input  1  PC <= PC+1.
- call  input  1  push PC+1, then PC <= in.
- ret  input  1  pop top of stack into PC.
- in  input  WIDTH  jump/call target.
- out  output  WIDTH  current PC (registered).
- depth  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- overflow  output  1  sticky: call attempted while stack full.
- underflow  output  1  sticky: ret attempted while stack empty.

Behaviour:
- All outputs registered. Effect of a command is visible on `out` the cycle after the edge that samples it (1-cycle latency). No combinational path from any input to any output.
- Reset (synchronous, active-high):
  - out = RESET_VECTOR, depth = 0, overflow = 0, underflow = 0.
  - Stack contents are don't-care after reset.
  - Reset mid-sequence discards all pending stack entries.
- Priority when several controls are high in one cycle: reset > load > call > ret > increment > hold.
  - Only the winning command takes effect.
  - Example: load+call = plain jump, no push.
  - Example: call+ret = call only.
- Hold (no control high): out, depth and flags unchanged.
- increment: out <= out + 1 mod 2^WIDTH. All-ones wraps to 0.
- load: out <= in. Stack untouched.
- call, depth < STACK_DEPTH:
  - stack[depth] <= out + 1 mod 2^WIDTH.
  - depth <= depth + 1.
  - out <= in.
- call, depth == STACK_DEPTH:
  - out <= in.
  - No push, stack and depth unchanged.
  - overflow <= 1.
- ret, depth > 0:
  - out <= stack[depth-1].
  - depth <= depth - 1.
- ret, depth == 0:
  - out unchanged, depth stays 0.
  - underflow <= 1.
- overflow and underflow, once set, remain 1 until reset. No other command clears them.
- LIFO order strictly preserved. A push followed by a pop returns exactly the pushed value.
- Stack implemented as a register array indexed by depth. No read-before-write hazard: push and pop never occur in the same cycle.

Test Plan:
- Reset with RESET_VECTOR=0x0010 -> out=0x0010, depth=0, overflow=0, underflow=0; then hold 3 cycles -> out stays 0x0010.
- Increment at out=0xFFFE for 2 cycles -> out=0xFFFF then 0x0000. Assert load with in=0x1234 together with increment -> out=0x1234.
- From out=0x0005, call in=0x0100 -> out=0x0100, depth=1. Increment twice -> 0x0102. ret -> out=0x0006, depth=0.
- Nested calls (STACK_DEPTH=8) from out=0x0000, 0x0010, ... eight times -> depth=8. Ninth call in=0x0900 -> out=0x0900, depth=8, overflow=1. Eight rets -> return addresses in reverse push order, depth=0, overflow still 1.
- ret at depth=0 with out=0x0042 -> out=0x0042, underflow=1. Later valid call/ret -> underflow stays 1 until reset.
- Simultaneous events:
  - call+ret with in=0x0200 at out=0x0007 -> out=0x0200, depth+1, top=0x0008.
  - reset asserted together with call at depth=3 -> out=RESET_VECTOR, depth=0, flags 0.
